fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch initiator for the ROM read port. Holds the fetch PC, issues one
//  4-byte ROM read per cycle, buffers returned words in a small prefetch queue and
//  hands them to the decoder over a valid/ready handshake. Sits between the ROM
//  (0x8000-0xFFFC window, one-cycle read latency) and the decode stage.
// PARAMETERS
//  RESET_PC   16'h8000  PC loaded on reset
//  ROM_BASE   16'h8000  lowest fetchable address
//  ROM_LAST   16'hFFFC  highest fetchable address (base of last 4-byte word)
//  DEPTH      4         prefetch queue entries (power of two, >=2)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  rom_a        out  16  ROM read address (registered)
//  rom_re       out  1   ROM read enable (registered)
//  rom_q0..q3   in   8   ROM read bytes, addr+0..addr+3, valid one cycle after issue
//  ins_valid    out  1   ins_data/ins_pc hold a fetched word
//  ins_ready    in   1   decoder accepts word when ins_valid & ins_ready at posedge
//  ins_data     out  32  fetched word {q3,q2,q1,q0} (little-endian)
//  ins_pc       out  16  address of ins_data
//  redirect     in   1   branch/jump: discard all fetched and in-flight words
//  redirect_pc  in   16  new fetch PC, sampled when redirect=1
//  fault        out  1   sticky: fetch PC left [ROM_BASE, ROM_LAST]
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, rom_re=0, rom_a=0, queue empty, ins_valid=0,
//   ins_data=0, ins_pc=0, fault=0, inflight=0, state=RUN.
//  States: RUN (issuing), STALL (no credit), FAULT (out-of-window PC).
//  Issue (RUN): when pc in window and count+inflight < DEPTH: rom_re=1, rom_a=pc next
//   cycle, pc+=4, inflight=1. Otherwise rom_re=0. Max one request per cycle.
//  Return: response to request driven in cycle N is captured into the queue at the posedge
//   ending cycle N+1, tagged with its address. Captured data is never z/x-checked.
//  Credit: count includes the word being popped the same cycle, so full queue + pop
//   admits a new issue the next cycle; back-to-back issue sustained while ins_ready=1.
//  STALL: entered when no credit; returns to RUN the cycle credit reappears.
//  Output: ins_valid = queue non-empty; ins_data/ins_pc = head entry (first-word
//   fall-through, combinational from queue head). Pop on ins_valid & ins_ready.
//  Simultaneous capture + pop: both happen; count unchanged.
//  Redirect (highest priority): at posedge with redirect=1: queue flushed, in-flight
//   response dropped (kill flag, not captured), pc=redirect_pc, fault cleared,
//   rom_re=0 that cycle; issue resumes next cycle. ins_valid=0 the cycle after.
//   Redirect overrides a same-cycle pop (pop is a no-op on the flushed queue).
//  Window: pc outside [ROM_BASE, ROM_LAST] -> no issue, state=FAULT, fault=1 once queue
//   and in-flight drain (older valid words still delivered). pc 0xFFFC+4 wraps to 0x0000
//   -> FAULT. Only redirect (or reset) leaves FAULT; redirect to a bad PC re-faults.
//  redirect_pc need not be 4-aligned; fetch proceeds from it in steps of 4.
//  Reset mid-operation: all state cleared immediately; in-flight response ignored.
// TESTING
//  1 Reset, ROM bytes 0x8000..0x800B=00..0B, ins_ready=1 -> words 0x03020100@8000,
//    0x07060504@8004, 0x0B0A0908@8008 on consecutive cycles, first ins_valid 2 cycles
//    after reset release.
//  2 ins_ready=0 for 10 cycles -> exactly DEPTH=4 words queued, rom_re=0 in STALL; raise
//    ins_ready -> words delivered in order, no gap, no duplicate or missing PC.
//  3 redirect=1, redirect_pc=0x9000 while queue full and one read in flight -> next
//    delivered word has ins_pc=0x9000; no pre-redirect word appears afterwards.
//  4 redirect_pc=0xFFF8 -> words @FFF8, @FFFC delivered, then fault=1, rom_re stays 0,
//    ins_valid=0; redirect to 0x8000 clears fault, fetch resumes.
//  5 redirect_pc=0x1000 -> fault=1, no rom_re pulse, ins_valid never set.
//  6 assert rst_n=0 mid-stream with read in flight -> all outputs at reset values
//    immediately; after release fetch restarts at 0x8000.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch initiator with prefetch queue and redirect
//
// Purpose: holds the fetch PC and issues one 4-byte ROM read per cycle while
// the prefetch queue has room. Words come back one cycle after the request and
// are queued with their address. The decoder takes them over a valid/ready
// handshake. A redirect flushes everything and restarts fetch at a new PC. A PC
// outside [ROM_BASE, ROM_LAST] stops fetch, and fault is raised once the older
// words have drained.
//
// Ports:
//   clk_i           clock, all state on posedge
//   rst_ni          asynchronous active-low reset
//   rom_a_o         ROM read address (registered)
//   rom_re_o        ROM read enable (registered)
//   rom_q0_i..q3_i  ROM read bytes addr+0..addr+3, valid the cycle after a request
//   ins_valid_o     ins_data_o/ins_pc_o hold a fetched word
//   ins_ready_i     decoder accepts the head word this cycle
//   ins_data_o      fetched word {q3,q2,q1,q0}
//   ins_pc_o        address of ins_data_o
//   redirect_i      discard all fetched and in-flight words
//   redirect_pc_i   new fetch PC, used when redirect_i=1
//   fault_o         sticky out-of-window indication
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h8000,
  parameter logic [15:0] ROM_BASE = 16'h8000,
  parameter logic [15:0] ROM_LAST = 16'hFFFC,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] rom_a_o,
  output logic        rom_re_o,
  input  logic [7:0]  rom_q0_i,
  input  logic [7:0]  rom_q1_i,
  input  logic [7:0]  rom_q2_i,
  input  logic [7:0]  rom_q3_i,
  output logic        ins_valid_o,
  input  logic        ins_ready_i,
  output logic [31:0] ins_data_o,
  output logic [15:0] ins_pc_o,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        fault_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [15:0]      pc_q, pc_d;
  logic [1:0]       state_q, state_d;
  logic             rom_re_q, rom_re_d;
  logic [15:0]      rom_a_q, rom_a_d;
  logic             resp_pend_q, resp_pend_d;   // ROM data for the last request is on rom_q now
  logic [15:0]      resp_pc_q, resp_pc_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] q_data [DEPTH];
  logic [15:0] q_pc   [DEPTH];

  logic           in_window;
  logic [CNT_W:0] occupancy;
  logic           has_credit;
  logic           issue;
  logic           push;
  logic           pop;
  logic           drained;

  assign in_window = (pc_q >= ROM_BASE) && (pc_q <= ROM_LAST);

  // Every request already made will land in the queue, so it reserves a slot.
  // A word being popped this cycle still counts: its slot frees up next cycle.
  assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, rom_re_q} + {{CNT_W{1'b0}}, resp_pend_q};
  assign has_credit = occupancy < DEPTH_C;
  assign issue      = !redirect_i && in_window && has_credit;

  assign ins_valid_o = (count_q != '0);
  assign push        = resp_pend_q && !redirect_i;
  assign pop         = ins_valid_o && ins_ready_i && !redirect_i;
  assign drained     = (count_q == '0) && !rom_re_q && !resp_pend_q;

  assign ins_data_o = ins_valid_o ? q_data[rd_ptr_q] : 32'h0;
  assign ins_pc_o   = ins_valid_o ? q_pc[rd_ptr_q] : 16'h0;
  assign rom_a_o    = rom_a_q;
  assign rom_re_o   = rom_re_q;
  assign fault_o    = fault_q;

  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    rom_re_d    = 1'b0;
    rom_a_d     = rom_a_q;
    resp_pend_d = 1'b0;
    resp_pc_d   = resp_pc_q;
    fault_d     = fault_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    if (redirect_i) begin
      // Clearing resp_pend kills the response to a request still on the ROM port.
      pc_d     = redirect_pc_i;
      state_d  = S_RUN;
      fault_d  = 1'b0;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      resp_pend_d = rom_re_q;
      resp_pc_d   = rom_a_q;

      if (issue) begin
        rom_re_d = 1'b1;
        rom_a_d  = pc_q;
        pc_d     = pc_q + 16'd4;
      end

      if (!in_window) begin
        state_d = S_FAULT;
      end else if (has_credit) begin
        state_d = S_RUN;
      end else begin
        state_d = S_STALL;
      end

      // Older words are still handed out before the fault becomes visible.
      if (state_q == S_FAULT && drained) begin
        fault_d = 1'b1;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= RESET_PC;
      state_q     <= S_RUN;
      rom_re_q    <= 1'b0;
      rom_a_q     <= 16'h0;
      resp_pend_q <= 1'b0;
      resp_pc_q   <= 16'h0;
      fault_q     <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      state_q     <= state_d;
      rom_re_q    <= rom_re_d;
      rom_a_q     <= rom_a_d;
      resp_pend_q <= resp_pend_d;
      resp_pc_q   <= resp_pc_d;
      fault_q     <= fault_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_data[wr_ptr_q] <= {rom_q3_i, rom_q2_i, rom_q1_i, rom_q0_i};
      q_pc[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule
